morra_tabellone: RTL and testbench
==================================

# morra_tabellone

Scoreboard stage placed directly downstream of the MorraCinese FSMD. Every cycle it samples that block's registered MANCHE and PARTITA outputs and keeps per-game tallies of round results and a short history of recent rounds. It also counts completed games across a session and pulses a game-over event for display/logging logic. It shares the clock and the INIZIO start strobe with MorraCinese; it never drives the game FSMD.

## Interface
Parameters:
- CW, 4, width of per-game round counters (saturating)
- SW, 8, width of session game counters (saturating)
- HIST, 8, number of rounds kept in the history register

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset; priority over every other input
- INIZIO  in  1  same start strobe driven into MorraCinese
- MANCHE  in  2  round result: 00 invalid/no round, 01 player 1 wins, 10 player 2 wins, 11 draw
- PARTITA  in  2  game result: 00 in progress, 01 player 1 wins, 10 player 2 wins, 11 tie
- VINTE1  out  CW  rounds won by player 1, current game
- VINTE2  out  CW  rounds won by player 2, current game
- PAREGGI  out  CW  drawn rounds, current game
- GIOCATE  out  CW  valid (non-00) rounds, current game
- PARTITE1  out  SW  games won by player 1 since RST
- PARTITE2  out  SW  games won by player 2 since RST
- PARTITEPARI  out  SW  tied games since RST
- STORIA  out  2*HIST  last HIST valid MANCHE codes, [1:0] newest
- ATTIVA  out  1  high while a game is being tallied
- FINE  out  1  one-cycle pulse on game completion

## Operation
- Alignment: MorraCinese registers its result at the edge that samples INIZIO and the moves. This block therefore delays INIZIO by one register (ini_d). ini_d and MANCHE/PARTITA for the same round are sampled together at the following edge.
- States: IDLE (after reset), GIOCO, FINITA. ATTIVA = (state == GIOCO).
- IDLE: samples ignored until ini_d = 1.
- ini_d = 1, any state, at one sample:
  - Clear VINTE1, VINTE2, PAREGGI, GIOCATE and STORIA.
  - Enter GIOCO.
  - Process the same sample as the first round of the new game (clear, then count).
- GIOCO, per sample:
  - MANCHE 01 → VINTE1+1.
  - MANCHE 10 → VINTE2+1.
  - MANCHE 11 → PAREGGI+1.
  - Any non-00 MANCHE → GIOCATE+1, and STORIA shifts left by 2 with MANCHE inserted at [1:0].
  - MANCHE 00 → no counter or history change.
- GIOCO with PARTITA ≠ 00 at a sample:
  - Count that sample's MANCHE as above.
  - Increment PARTITE1 (01), PARTITE2 (10) or PARTITEPARI (11).
  - Assert FINE and go to FINITA.
  - This also applies when ini_d = 1 in the same sample: the game starts and ends.
- FINITA: MANCHE and PARTITA are ignored; per-game counters and STORIA hold for display until ini_d = 1 or RST.
- Saturation: every counter stops at all-ones and never wraps. GIOCATE saturates independently of the other counters.
- Session counters are cleared only by RST, never by INIZIO.

## Timing
- RST sampled high → at that edge every output becomes 0, state IDLE, ini_d 0. The current sample is not counted.
- RST deasserted mid-game → the block stays in IDLE until a new INIZIO; no partial tallies survive.
- Latency: INIZIO high at edge k → ATTIVA and the first-round counts visible after edge k+1.
- Round/game latency: a MANCHE or PARTITA value sampled at edge n is reflected in the outputs after edge n.
- FINE is high for exactly the one cycle following the ending sample, then low. It never re-asserts in FINITA, even if PARTITA stays ≠ 00.
- Back-to-back INIZIO: each pulse restarts the game; only the last restart's counts remain.

## Test plan
- Reset: assert RST 2 cycles mid-activity → all outputs 0, ATTIVA 0, FINE 0; MANCHE=01 without INIZIO leaves VINTE1=0.
- Start alignment: INIZIO=1 at edge k, MANCHE=01 presented for edge k+1 → after k+1 ATTIVA=1, VINTE1=1, GIOCATE=1, STORIA[1:0]=01.
- Mixed rounds: sequence 10,11,00,01 → VINTE1=1, VINTE2=1, PAREGGI=1, GIOCATE=3, STORIA[5:0]=10_11_01; the 00 round leaves the history unchanged.
- Game end: PARTITA=10 sampled with MANCHE=10 → VINTE2+1, PARTITE2=1, FINE high one cycle, ATTIVA=0; further MANCHE=01 leaves VINTE1 unchanged.
- Saturation (CW=4): 17 consecutive MANCHE=11 in GIOCO → PAREGGI=15, GIOCATE=15; no wrap.
- Restart: INIZIO mid-game after one finished game → per-game counters restart from the new first round, PARTITE counters retained; a following RST clears PARTITE counters to 0.

Source files
------------

// File: rtl/morra_tabellone.sv
// Scoreboard stage behind the MorraCinese FSMD: per-game round tallies, recent round history,
// session game counters and a one-cycle game-over pulse.
module morra_tabellone #(
    parameter int CW   = 4,
    parameter int SW   = 8,
    parameter int HIST = 8
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                INIZIO,
    input  logic [1:0]          MANCHE,
    input  logic [1:0]          PARTITA,
    output logic [CW-1:0]       VINTE1,
    output logic [CW-1:0]       VINTE2,
    output logic [CW-1:0]       PAREGGI,
    output logic [CW-1:0]       GIOCATE,
    output logic [SW-1:0]       PARTITE1,
    output logic [SW-1:0]       PARTITE2,
    output logic [SW-1:0]       PARTITEPARI,
    output logic [2*HIST-1:0]   STORIA,
    output logic                ATTIVA,
    output logic                FINE
);

    typedef enum logic [1:0] {IDLE, GIOCO, FINITA} stato_t;

    stato_t             stato, stato_n;
    logic               ini_d;
    logic               conta;
    logic [CW-1:0]      vinte1_n, vinte2_n, pareggi_n, giocate_n;
    logic [SW-1:0]      partite1_n, partite2_n, partitepari_n;
    logic [2*HIST-1:0]  storia_n;
    logic               fine_n;

    function automatic logic [CW-1:0] sat_cw(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    function automatic logic [SW-1:0] sat_sw(input logic [SW-1:0] v);
        return (&v) ? v : v + SW'(1);
    endfunction

    // A delayed start strobe lines up with the round result MorraCinese registers for it.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
        stato_n       = stato;
        vinte1_n      = VINTE1;
        vinte2_n      = VINTE2;
        pareggi_n     = PAREGGI;
        giocate_n     = GIOCATE;
        partite1_n    = PARTITE1;
        partite2_n    = PARTITE2;
        partitepari_n = PARTITEPARI;
        storia_n      = STORIA;
        fine_n        = 1'b0;
        conta         = 1'b0;

        if (ini_d) begin
            vinte1_n  = '0;
            vinte2_n  = '0;
            pareggi_n = '0;
            giocate_n = '0;
            storia_n  = '0;
            conta     = 1'b1;
        end else if (stato == GIOCO) begin
            conta = 1'b1;
        end

        // The starting sample is cleared first and then counted as the first round.
        if (conta) begin
            stato_n = GIOCO;
            case (MANCHE)
                2'b01:   vinte1_n  = sat_cw(vinte1_n);
                2'b10:   vinte2_n  = sat_cw(vinte2_n);
                2'b11:   pareggi_n = sat_cw(pareggi_n);
                default: ;
            endcase
            if (MANCHE != 2'b00) begin
                giocate_n = sat_cw(giocate_n);
                storia_n  = {storia_n[2*HIST-3:0], MANCHE};
            end
            if (PARTITA != 2'b00) begin
                case (PARTITA)
                    2'b01:   partite1_n    = sat_sw(partite1_n);
                    2'b10:   partite2_n    = sat_sw(partite2_n);
                    default: partitepari_n = sat_sw(partitepari_n);
                endcase
                fine_n  = 1'b1;
                stato_n = FINITA;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
        if (RST) begin
            stato       <= IDLE;
            ini_d       <= 1'b0;
            VINTE1      <= '0;
            VINTE2      <= '0;
            PAREGGI     <= '0;
            GIOCATE     <= '0;
            PARTITE1    <= '0;
            PARTITE2    <= '0;
            PARTITEPARI <= '0;
            STORIA      <= '0;
            FINE        <= 1'b0;
        end else begin
            stato       <= stato_n;
            ini_d       <= INIZIO;
            VINTE1      <= vinte1_n;
            VINTE2      <= vinte2_n;
            PAREGGI     <= pareggi_n;
            GIOCATE     <= giocate_n;
            PARTITE1    <= partite1_n;
            PARTITE2    <= partite2_n;
            PARTITEPARI <= partitepari_n;
            STORIA      <= storia_n;
            FINE        <= fine_n;
        end
    end

    assign ATTIVA = (stato == GIOCO);

endmodule

// File: tb/tb_morra_tabellone.sv
// Self-checking bench for morra_tabellone: directed scenarios with literal expectations,
// then randomized play compared every cycle against a tally model.
module tb_morra_tabellone;

    localparam int CW   = 4;
    localparam int SW   = 8;
    localparam int HIST = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int SMAX = (1 << SW) - 1;

    logic               clk;
    logic               RST;
    logic               INIZIO;
    logic [1:0]         MANCHE;
    logic [1:0]         PARTITA;
    logic [CW-1:0]      VINTE1, VINTE2, PAREGGI, GIOCATE;
    logic [SW-1:0]      PARTITE1, PARTITE2, PARTITEPARI;
    logic [2*HIST-1:0]  STORIA;
    logic               ATTIVA, FINE;

    morra_tabellone #(.CW(CW), .SW(SW), .HIST(HIST)) dut (
        .clk(clk), .RST(RST), .INIZIO(INIZIO), .MANCHE(MANCHE), .PARTITA(PARTITA),
        .VINTE1(VINTE1), .VINTE2(VINTE2), .PAREGGI(PAREGGI), .GIOCATE(GIOCATE),
        .PARTITE1(PARTITE1), .PARTITE2(PARTITE2), .PARTITEPARI(PARTITEPARI),
        .STORIA(STORIA), .ATTIVA(ATTIVA), .FINE(FINE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Tally model: plain integers, a queue of recent rounds, and whether a game is running.
    int         m_v1, m_v2, m_pp, m_gg, m_p1, m_p2, m_pt;
    logic [1:0] m_hist[$];
    bit         m_playing, m_fine, m_start_seen;

    function automatic int inc(input int v, input int lim);
        return (v < lim) ? v + 1 : v;
    endfunction

    function automatic logic [2*HIST-1:0] hist_word();
        logic [2*HIST-1:0] w = '0;
        for (int i = 0; i < m_hist.size(); i++) w[2*i +: 2] = m_hist[i];
        return w;
    endfunction

    initial begin
        {m_v1, m_v2, m_pp, m_gg, m_p1, m_p2, m_pt} = '{default: 0};
        m_playing = 0; m_fine = 0; m_start_seen = 0;
    end

    always @(posedge clk) begin
        if (RST) begin
            {m_v1, m_v2, m_pp, m_gg, m_p1, m_p2, m_pt} = '{default: 0};
            m_hist.delete();
            m_playing = 0; m_fine = 0; m_start_seen = 0;
        end else begin
            bit round_counts;
            m_fine = 0;
            round_counts = m_playing;
            if (m_start_seen) begin
                m_v1 = 0; m_v2 = 0; m_pp = 0; m_gg = 0;
                m_hist.delete();
                round_counts = 1;
            end
            if (round_counts) begin
                if (MANCHE == 2'b01) m_v1 = inc(m_v1, CMAX);
                if (MANCHE == 2'b10) m_v2 = inc(m_v2, CMAX);
                if (MANCHE == 2'b11) m_pp = inc(m_pp, CMAX);
                if (MANCHE != 2'b00) begin
                    m_gg = inc(m_gg, CMAX);
                    m_hist.push_front(MANCHE);
                    if (m_hist.size() > HIST) void'(m_hist.pop_back());
                end
                m_playing = 1;
                if (PARTITA != 2'b00) begin
                    if (PARTITA == 2'b01) m_p1 = inc(m_p1, SMAX);
                    if (PARTITA == 2'b10) m_p2 = inc(m_p2, SMAX);
                    if (PARTITA == 2'b11) m_pt = inc(m_pt, SMAX);
                    m_fine    = 1;
                    m_playing = 0;
                end
            end
            m_start_seen = INIZIO;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("VINTE1",      32'(VINTE1),      32'(m_v1));
            check("VINTE2",      32'(VINTE2),      32'(m_v2));
            check("PAREGGI",     32'(PAREGGI),     32'(m_pp));
            check("GIOCATE",     32'(GIOCATE),     32'(m_gg));
            check("PARTITE1",    32'(PARTITE1),    32'(m_p1));
            check("PARTITE2",    32'(PARTITE2),    32'(m_p2));
            check("PARTITEPARI", 32'(PARTITEPARI), 32'(m_pt));
            check("STORIA",      32'(STORIA),      32'(hist_word()));
            check("ATTIVA",      32'(ATTIVA),      32'(m_playing));
            check("FINE",        32'(FINE),        32'(m_fine));
        end
    end

    // Inputs change 1 ns after a rising edge, so the next edge samples them cleanly.
    task automatic step(input logic rst, input logic ini, input logic [1:0] m, input logic [1:0] p);
        RST = rst; INIZIO = ini; MANCHE = m; PARTITA = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        RST = 1'b1; INIZIO = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00;
        step(1, 0, 2'b00, 2'b00);
        cmp_en = 1'b1;

        // Some activity, then a two-cycle reset mid-game
        step(0, 1, 2'b00, 2'b00);
        step(0, 0, 2'b01, 2'b00);
        step(0, 0, 2'b10, 2'b00);
        step(1, 0, 2'b01, 2'b00);
        step(1, 0, 2'b01, 2'b00);
        check("rst_vinte1", 32'(VINTE1), 0);
        check("rst_storia", 32'(STORIA), 0);
        check("rst_attiva", 32'(ATTIVA), 0);
        check("rst_fine",   32'(FINE),   0);
        step(0, 0, 2'b01, 2'b00);
        check("idle_ignores_manche", 32'(VINTE1), 0);

        // Start alignment
        step(0, 1, 2'b00, 2'b00);
        check("attiva_before_first_round", 32'(ATTIVA), 0);
        step(0, 0, 2'b01, 2'b00);
        check("start_attiva",  32'(ATTIVA),      1);
        check("start_vinte1",  32'(VINTE1),      1);
        check("start_giocate", 32'(GIOCATE),     1);
        check("start_storia",  32'(STORIA[1:0]), 32'(2'b01));

        // Mixed rounds in a fresh game
        step(0, 1, 2'b00, 2'b00);
        step(0, 0, 2'b10, 2'b00);
        step(0, 0, 2'b11, 2'b00);
        step(0, 0, 2'b00, 2'b00);
        step(0, 0, 2'b01, 2'b00);
        check("mix_vinte1",  32'(VINTE1),      1);
        check("mix_vinte2",  32'(VINTE2),      1);
        check("mix_pareggi", 32'(PAREGGI),     1);
        check("mix_giocate", 32'(GIOCATE),     3);
        check("mix_storia",  32'(STORIA),      32'h0000_0000 | 32'b10_11_01);

        // Game end
        step(0, 0, 2'b10, 2'b10);
        check("end_vinte2",   32'(VINTE2),   2);
        check("end_partite2", 32'(PARTITE2), 1);
        check("end_fine",     32'(FINE),     1);
        check("end_attiva",   32'(ATTIVA),   0);
        step(0, 0, 2'b01, 2'b10);
        check("finita_fine_low", 32'(FINE),     0);
        check("finita_vinte1",   32'(VINTE1),   1);
        check("finita_partite2", 32'(PARTITE2), 1);

        // Saturation of per-game counters
        step(0, 1, 2'b00, 2'b00);
        for (int i = 0; i < 17; i++) step(0, 0, 2'b11, 2'b00);
        check("sat_pareggi", 32'(PAREGGI), 15);
        check("sat_giocate", 32'(GIOCATE), 15);
        check("sat_storia",  32'(STORIA),  32'hFFFF);

        // Restart mid-game keeps session counters
        step(0, 1, 2'b11, 2'b00);
        step(0, 0, 2'b01, 2'b00);
        check("restart_vinte1",   32'(VINTE1),   1);
        check("restart_pareggi",  32'(PAREGGI),  0);
        check("restart_giocate",  32'(GIOCATE),  1);
        check("restart_storia",   32'(STORIA),   1);
        check("restart_partite2", 32'(PARTITE2), 1);
        step(0, 0, 2'b01, 2'b01);
        check("p1_win_partite1", 32'(PARTITE1), 1);

        // Game that starts and ends on the same sample
        step(0, 1, 2'b00, 2'b00);
        step(0, 0, 2'b11, 2'b11);
        check("oneshot_pari", 32'(PARTITEPARI), 1);
        check("oneshot_fine", 32'(FINE),        1);
        check("oneshot_gg",   32'(GIOCATE),     1);

        step(1, 0, 2'b00, 2'b00);
        check("rst_partite1",    32'(PARTITE1),    0);
        check("rst_partite2",    32'(PARTITE2),    0);
        check("rst_partitepari", 32'(PARTITEPARI), 0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            logic       r, s;
            logic [1:0] m, p;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 24) == 0);
            m = 2'($urandom_range(0, 3));
            p = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(r, s, m, p);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
